chimera_cluster_pwr_ctrl: RTL

CHIMERA_CLUSTER_PWR_CTRL -- requirements
Module: chimera_cluster_pwr_ctrl

---
 rtl/chimera_cluster_pwr_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/chimera_cluster_pwr_ctrl.sv
// -----------------------------------------------------------------------------
// chimera_cluster_pwr_ctrl
//
// Power sequencer for a set of compute clusters, programmed over APB. Each
// cluster has its own sequencing FSM that walks through clock ungating, reset
// release, AXI isolation release, and the reverse order on power-down.
//
// Register map (paddr_i[3:0], upper address bits ignored):
//   0x0 CTRL   RW  bit i = enable request for cluster i
//   0x4 STATUS RO  bit i = cluster i fully on
//   0x8 BUSY   RO  bit i = cluster i in a transient state
// Any other offset, or a write to STATUS/BUSY, returns pslverr_o with
// prdata_o = 0 and has no effect. Zero wait states (pready_o tied high).
// NumClusters must not exceed 32 (one CTRL bit per cluster).
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   paddr_i .. pstrb_i    APB slave request
//   pready_o, prdata_o,
//   pslverr_o             APB slave response
//   isolated_i            per-cluster AXI isolation acknowledge
//   clk_en_o              per-cluster clock-gate enable
//   cluster_rst_o         per-cluster reset, active-high
//   isolate_o             per-cluster AXI isolation request
// -----------------------------------------------------------------------------
module chimera_cluster_pwr_ctrl #(
    parameter int unsigned NumClusters = 5,
    parameter int unsigned ResetCycles = 4,
    parameter int unsigned AddrWidth   = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [AddrWidth-1:0]   paddr_i,
    input  logic                   psel_i,
    input  logic                   penable_i,
    input  logic                   pwrite_i,
    input  logic [31:0]            pwdata_i,
    input  logic [3:0]             pstrb_i,
    output logic                   pready_o,
    output logic [31:0]            prdata_o,
    output logic                   pslverr_o,
    input  logic [NumClusters-1:0] isolated_i,
    output logic [NumClusters-1:0] clk_en_o,
    output logic [NumClusters-1:0] cluster_rst_o,
    output logic [NumClusters-1:0] isolate_o
);

    typedef enum logic [2:0] {
        StOff,
        StUngate,
        StRelease,
        StOn,
        StIsolate,
        StHold,
        StGate
    } clusterState_e;

    localparam logic [7:0] LastCnt = 8'(ResetCycles - 1);

    logic                   apbAccess;
    logic [NumClusters-1:0] ctrlQ;
    logic [NumClusters-1:0] statusBits;
    logic [NumClusters-1:0] busyBits;
    logic                   unusedApb;

    assign apbAccess = psel_i & penable_i;
    assign pready_o  = 1'b1;

    // Only the low offset nibble, the CTRL-sized slice of pwdata_i and the
    // strobes covering it are meaningful; the rest is intentionally ignored.
    assign unusedApb = ^{paddr_i, pwdata_i, pstrb_i};

    // -------------------------------------------------------------------------
    // CTRL register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrlQ <= '0;
        end else if (apbAccess && pwrite_i && (paddr_i[3:0] == 4'h0)) begin
            for (int unsigned i = 0; i < NumClusters; i++) begin
                if (pstrb_i[i / 8]) begin
                    ctrlQ[i] <= pwdata_i[i];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // APB read / error response (combinational so the access phase completes
    // with zero wait states; forced quiet while reset is asserted)
    // -------------------------------------------------------------------------
    always_comb begin
        logic [31:0] rdata;
        logic        err;
        rdata     = '0;
        err       = 1'b0;
        prdata_o  = '0;
        pslverr_o = 1'b0;
        if (apbAccess && !rst_i) begin
            case (paddr_i[3:0])
                4'h0: rdata[NumClusters-1:0] = ctrlQ;
                4'h4: begin
                    rdata[NumClusters-1:0] = statusBits;
                    err                    = pwrite_i;
                end
                4'h8: begin
                    rdata[NumClusters-1:0] = busyBits;
                    err                    = pwrite_i;
                end
                default: err = 1'b1;
            endcase
            pslverr_o = err;
            if (!pwrite_i && !err) begin
                prdata_o = rdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-cluster sequencing FSMs
    // -------------------------------------------------------------------------
    for (genvar c = 0; c < NumClusters; c++) begin : gCluster
        clusterState_e state;
        logic [7:0]    cnt;
        logic          clkEnQ;
        logic          rstQ;
        logic          isoQ;

        // Outputs are updated together with the state transition so each one
        // is a plain flop: only the signals that differ between the old and
        // the new state are touched on a transition.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state  <= StOff;
                cnt    <= '0;
                clkEnQ <= 1'b0;
                rstQ   <= 1'b1;
                isoQ   <= 1'b1;
            end else begin
                case (state)
                    StOff: begin
                        if (ctrlQ[c]) begin
                            state  <= StUngate;
                            clkEnQ <= 1'b1;
                        end
                    end
                    StUngate: begin
                        if (cnt == LastCnt) begin
                            cnt   <= '0;
                            state <= StRelease;
                            rstQ  <= 1'b0;
                            isoQ  <= 1'b0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    StRelease: begin
                        if (!isolated_i[c]) begin
                            state <= StOn;
                        end
                    end
                    StOn: begin
                        if (!ctrlQ[c]) begin
                            state <= StIsolate;
                            isoQ  <= 1'b1;
                        end
                    end
                    StIsolate: begin
                        if (isolated_i[c]) begin
                            state <= StHold;
                            rstQ  <= 1'b1;
                        end
                    end
                    StHold: begin
                        if (cnt == LastCnt) begin
                            cnt    <= '0;
                            state  <= StGate;
                            clkEnQ <= 1'b0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    StGate: begin
                        state <= StOff;
                    end
                    default: begin
                        state  <= StOff;
                        cnt    <= '0;
                        clkEnQ <= 1'b0;
                        rstQ   <= 1'b1;
                        isoQ   <= 1'b1;
                    end
                endcase
            end
        end

        assign clk_en_o[c]      = clkEnQ;
        assign cluster_rst_o[c] = rstQ;
        assign isolate_o[c]     = isoQ;
        assign statusBits[c]    = (state == StOn);
        assign busyBits[c]      = (state != StOn) && (state != StOff);
    end

endmodule
